bank_cmd_arbiter: RTL and testbench
===================================

BANK_CMD_ARBITER -- requirements
Module: bank_cmd_arbiter

Interface
REQ-001 Parameter: NBANKS, default 8, number of bank machine command sources.
REQ-002 Parameter: AW, default 17, width of the address/row field.
REQ-003 Port: sys_clk, input, 1, the only clock; rising edge.
REQ-004 Port: sys_rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port: bm_cmd_valid, input, NBANKS, per-bank command valid.
REQ-006 Port: bm_cmd_ready, output, NBANKS, per-bank accept (one-hot or zero).
REQ-007 Port: bm_cmd_a, input, NBANKS*AW, per-bank address; bank i occupies bits [i*AW +: AW].
REQ-008 Port: bm_cmd_cas / bm_cmd_ras / bm_cmd_we / bm_cmd_is_cmd / bm_cmd_is_read / bm_cmd_is_write, input, NBANKS each, per-bank command flags.
REQ-009 Port: out_valid, output, 1, arbitrated command valid.
REQ-010 Port: out_ready, input, 1, downstream accept.
REQ-011 Port: out_a, output, AW, registered address.
REQ-012 Port: out_ba, output, 3, index of the granted bank.
REQ-013 Port: out_cas / out_ras / out_we / out_is_cmd / out_is_read / out_is_write, output, 1 each, registered flags.
REQ-014 Port: tRRD_cfg / tFAW_cfg / tCCD_cfg, input, 8 each, timing in sys_clk cycles; quasi-static.

Function
REQ-015 Command classes:
- ACT = ras & ~cas & ~we & is_cmd.
- CAS = cas & (is_read | is_write).
- OTHER = any other command; OTHER has no timing constraint.
REQ-016 Eligibility: bank i is eligible when bm_cmd_valid[i] is high and:
- ACT: trrd_ok & faw_ok.
- CAS: tccd_ok.
- OTHER: always.
REQ-017 Slot free: slot_free = ~out_valid | out_ready.
REQ-018 Arbitration: round-robin over eligible banks, searching upward from (last_grant+1) mod NBANKS and wrapping.
REQ-019 Grant: when slot_free and any bank is eligible, assert bm_cmd_ready for exactly the winner in the same cycle (combinational).
REQ-020 Granting: load the output register next edge; set out_valid; update last_grant to the winner.
REQ-021 No grant: if slot_free and no bank is eligible, clear out_valid next edge. If not slot_free, hold the register and keep all bm_cmd_ready low.
REQ-022 Latency: exactly 1 cycle from bank acceptance to out_valid; throughput is 1 command per cycle with out_ready held high.
REQ-023 Output stability: payload stays constant while out_valid & ~out_ready.
REQ-024 Timing counter semantics, applied to tRRD and tCCD:
- Each counter is 8 bits.
- On a grant of its class, load max(cfg-1, 0).
- Otherwise decrement, saturating at 0.
- ok = (count == 0).
- Net effect: the next same-class grant occurs ≥ max(cfg, 1) cycles later.
REQ-025 tFAW window:
- Four 8-bit window counters.
- On each ACT grant, load tFAW_cfg-1 into the lowest-indexed counter that is 0.
- All counters decrement each cycle, saturating at 0.
- faw_ok = at least one counter is 0.
REQ-026 Counters update on grant (bank handshake), not on the downstream handshake.
REQ-027 last_grant is updated only on a grant; a bank dropping valid never moves the pointer.
REQ-028 Ready with no valid: bm_cmd_ready never asserts for a bank whose valid is low.

Reset
REQ-029 Asynchronous sys_rst values:
- out_valid = 0, and all out_* payload = 0.
- last_grant = NBANKS-1, so bank 0 has first priority.
- All timing counters = 0.
REQ-030 Reset mid-transfer: a held command is discarded and no bm_cmd_ready asserts while sys_rst is high.

Structure
REQ-031 Shared package holds:
- The command-class decode constants (ACT/CAS/OTHER).
- Bank-index width.
- Timing counter width (8).
REQ-032 Sub-module: one instance of timing_down_counter (load/decrement/saturate/ok) per tRRD, tCCD and each tFAW slot; the round-robin picker is inline.

Verification
REQ-033 Reset → bank 0 and bank 5 valid with OTHER, out_ready=1 → grants bank 0 then bank 5 on consecutive cycles; out_ba = 0 then 5.
REQ-034 tRRD_cfg=4; banks 1 and 2 both present ACT → bank 1 is granted at t; bank 2 is granted at t+4; bm_cmd_ready[2] stays low at t+1..t+3.
REQ-035 tFAW_cfg=20, tRRD_cfg=1; banks 0–4 issue ACT continuously → four grants at t..t+3; fifth grant no earlier than t+20.
REQ-036 tCCD_cfg=2, bank 3 CAS read and bank 4 ACT both valid → bank 3 is granted; next cycle bank 4's ACT is granted despite the CAS block; bank 3's next CAS is not granted before t+2.
REQ-037 out_ready=0 for 5 cycles with out_valid=1 → payload is constant and all bm_cmd_ready are 0; on out_ready=1, a new grant occurs in the same cycle.
REQ-038 sys_rst asserted mid-stream with out_valid=1 → out_valid=0 immediately, asynchronously; after release, bank 0 has priority.

Source files
------------

// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared definitions for the bank command arbiter: command classes, field widths
// and the decode/load-value helpers used by the top level.
package bank_cmd_arbiter_pkg;

    localparam int BANK_W    = 3;
    localparam int TCNT_W    = 8;
    localparam int FAW_SLOTS = 4;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_ACT   = 2'd1,
        CLS_CAS   = 2'd2
    } cmd_class_e;

    function automatic cmd_class_e decode_class(
        input logic ras,
        input logic cas,
        input logic we,
        input logic is_cmd,
        input logic is_read,
        input logic is_write
    );
        cmd_class_e cls;
        if (ras && !cas && !we && is_cmd) begin
            cls = CLS_ACT;
        end else if (cas && (is_read || is_write)) begin
            cls = CLS_CAS;
        end else begin
            cls = CLS_OTHER;
        end
        return cls;
    endfunction

    // A zero configuration behaves like one: the next same-class grant may follow immediately.
    function automatic logic [TCNT_W-1:0] load_value(input logic [TCNT_W-1:0] cfg);
        return (cfg == 8'd0) ? 8'd0 : (cfg - 8'd1);
    endfunction

endpackage

// File: rtl/bank_cmd_arbiter_if.sv
// Bank-machine command bus and arbitrated output bus of the bank command arbiter.
interface bank_cmd_arbiter_if
    import bank_cmd_arbiter_pkg::*;
#(
    parameter int NBANKS = 8,
    parameter int AW     = 17
);
    logic [NBANKS-1:0]    bm_cmd_valid;
    logic [NBANKS-1:0]    bm_cmd_ready;
    logic [NBANKS*AW-1:0] bm_cmd_a;
    logic [NBANKS-1:0]    bm_cmd_cas;
    logic [NBANKS-1:0]    bm_cmd_ras;
    logic [NBANKS-1:0]    bm_cmd_we;
    logic [NBANKS-1:0]    bm_cmd_is_cmd;
    logic [NBANKS-1:0]    bm_cmd_is_read;
    logic [NBANKS-1:0]    bm_cmd_is_write;

    logic                 out_valid;
    logic                 out_ready;
    logic [AW-1:0]        out_a;
    logic [BANK_W-1:0]    out_ba;
    logic                 out_cas;
    logic                 out_ras;
    logic                 out_we;
    logic                 out_is_cmd;
    logic                 out_is_read;
    logic                 out_is_write;

    modport slave (
        input  bm_cmd_valid, bm_cmd_a, bm_cmd_cas, bm_cmd_ras, bm_cmd_we,
               bm_cmd_is_cmd, bm_cmd_is_read, bm_cmd_is_write, out_ready,
        output bm_cmd_ready, out_valid, out_a, out_ba, out_cas, out_ras, out_we,
               out_is_cmd, out_is_read, out_is_write
    );

    modport master (
        output bm_cmd_valid, bm_cmd_a, bm_cmd_cas, bm_cmd_ras, bm_cmd_we,
               bm_cmd_is_cmd, bm_cmd_is_read, bm_cmd_is_write, out_ready,
        input  bm_cmd_ready, out_valid, out_a, out_ba, out_cas, out_ras, out_we,
               out_is_cmd, out_is_read, out_is_write
    );

endinterface

// File: rtl/bank_cmd_arbiter_timing_down_counter.sv
// Saturating down counter: loads on request, otherwise counts down to zero; ok while at zero.
module timing_down_counter
    import bank_cmd_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TCNT_W-1:0] load_val,
    output logic              ok
);
    logic [TCNT_W-1:0] count_r;

    // Load has priority over the saturating decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != 8'd0) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign ok = (count_r == 8'd0);

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Round-robin arbiter merging per-bank DRAM commands into one registered command
// stream while honouring tRRD, tCCD and the four-activate tFAW window.
module bank_cmd_arbiter
    import bank_cmd_arbiter_pkg::*;
#(
    parameter int NBANKS = 8,
    parameter int AW     = 17
)(
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    bank_cmd_arbiter_if.slave    bus,
    input  logic [TCNT_W-1:0]    tRRD_cfg,
    input  logic [TCNT_W-1:0]    tFAW_cfg,
    input  logic [TCNT_W-1:0]    tCCD_cfg
);
    cmd_class_e             cls_s [NBANKS];
    logic [NBANKS-1:0]      elig_s;
    logic [NBANKS-1:0]      ready_s;
    logic [BANK_W-1:0]      last_grant_r;
    logic [BANK_W-1:0]      win_s;
    logic                   found_s;
    logic                   slot_free_s;
    logic                   grant_s;
    logic                   act_grant_s;
    logic                   cas_grant_s;
    logic                   trrd_ok_s;
    logic                   tccd_ok_s;
    logic                   faw_ok_s;
    logic [FAW_SLOTS-1:0]   faw_zero_s;
    logic [FAW_SLOTS-1:0]   faw_load_s;
    logic                   faw_taken_s;

    logic                   out_valid_r;
    logic [AW-1:0]          out_a_r;
    logic [BANK_W-1:0]      out_ba_r;
    logic                   out_cas_r;
    logic                   out_ras_r;
    logic                   out_we_r;
    logic                   out_is_cmd_r;
    logic                   out_is_read_r;
    logic                   out_is_write_r;

    assign slot_free_s = !out_valid_r || bus.out_ready;
    assign faw_ok_s    = |faw_zero_s;

    // Classify every bank's command and gate it with the timing constraints of its class.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NBANKS; i++) begin
            cls_s[i] = decode_class(bus.bm_cmd_ras[i], bus.bm_cmd_cas[i], bus.bm_cmd_we[i],
                                    bus.bm_cmd_is_cmd[i], bus.bm_cmd_is_read[i],
                                    bus.bm_cmd_is_write[i]);
            case (cls_s[i])
                CLS_ACT: elig_s[i] = bus.bm_cmd_valid[i] && trrd_ok_s && faw_ok_s;
                CLS_CAS: elig_s[i] = bus.bm_cmd_valid[i] && tccd_ok_s;
                default: elig_s[i] = bus.bm_cmd_valid[i];
            endcase
        end
    end

    // Round-robin search starting just above the last granted bank.
    always_comb begin
        win_s   = last_grant_r;
        found_s = 1'b0;
        for (int k = 1; k <= NBANKS; k++) begin
            if (!found_s && elig_s[(int'(last_grant_r) + k) % NBANKS]) begin
                found_s = 1'b1;
                win_s   = BANK_W'((int'(last_grant_r) + k) % NBANKS);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Reset is folded in so no bank sees an accept while the block is held in reset.
    assign grant_s     = slot_free_s && found_s && !sys_rst;
    assign act_grant_s = grant_s && (cls_s[win_s] == CLS_ACT);
    assign cas_grant_s = grant_s && (cls_s[win_s] == CLS_CAS);

    // One-hot accept towards the winning bank.
    always_comb begin
        ready_s = '0;
        if (grant_s) begin
            ready_s[win_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign bus.bm_cmd_ready = ready_s;

    // Each activate occupies the lowest free tFAW slot until its window expires.
    always_comb begin
        faw_load_s  = '0;
        faw_taken_s = 1'b0;
        for (int k = 0; k < FAW_SLOTS; k++) begin
            if (act_grant_s && faw_zero_s[k] && !faw_taken_s) begin
                faw_load_s[k] = 1'b1;
                faw_taken_s   = 1'b1;
            end else begin
                faw_load_s[k] = 1'b0;
            end
        end
    end

    timing_down_counter u_trrd (
        .clk(sys_clk), .rst(sys_rst), .load(act_grant_s),
        .load_val(load_value(tRRD_cfg)), .ok(trrd_ok_s)
    );

    timing_down_counter u_tccd (
        .clk(sys_clk), .rst(sys_rst), .load(cas_grant_s),
        .load_val(load_value(tCCD_cfg)), .ok(tccd_ok_s)
    );

    for (genvar g = 0; g < FAW_SLOTS; g++) begin : g_faw
        timing_down_counter u_faw (
            .clk(sys_clk), .rst(sys_rst), .load(faw_load_s[g]),
            .load_val(load_value(tFAW_cfg)), .ok(faw_zero_s[g])
        );
    end

    // Output register: load on grant, drain when the slot frees with nothing to send, else hold.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_valid_r    <= 1'b0;
            out_a_r        <= '0;
            out_ba_r       <= 3'd0;
            out_cas_r      <= 1'b0;
            out_ras_r      <= 1'b0;
            out_we_r       <= 1'b0;
            out_is_cmd_r   <= 1'b0;
            out_is_read_r  <= 1'b0;
            out_is_write_r <= 1'b0;
            last_grant_r   <= BANK_W'(NBANKS - 1);
        end else if (grant_s) begin
            out_valid_r    <= 1'b1;
            out_a_r        <= bus.bm_cmd_a[int'(win_s) * AW +: AW];
            out_ba_r       <= win_s;
            out_cas_r      <= bus.bm_cmd_cas[win_s];
            out_ras_r      <= bus.bm_cmd_ras[win_s];
            out_we_r       <= bus.bm_cmd_we[win_s];
            out_is_cmd_r   <= bus.bm_cmd_is_cmd[win_s];
            out_is_read_r  <= bus.bm_cmd_is_read[win_s];
            out_is_write_r <= bus.bm_cmd_is_write[win_s];
            last_grant_r   <= win_s;
        end else if (slot_free_s) begin
            out_valid_r    <= 1'b0;
        end else begin
            out_valid_r    <= out_valid_r;
        end
    end

    assign bus.out_valid    = out_valid_r;
    assign bus.out_a        = out_a_r;
    assign bus.out_ba       = out_ba_r;
    assign bus.out_cas      = out_cas_r;
    assign bus.out_ras      = out_ras_r;
    assign bus.out_we       = out_we_r;
    assign bus.out_is_cmd   = out_is_cmd_r;
    assign bus.out_is_read  = out_is_read_r;
    assign bus.out_is_write = out_is_write_r;

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Self-checking bench for bank_cmd_arbiter: vector table, directed timing sequences
// and randomized traffic against a time-stamp based reference model.
module tb_bank_cmd_arbiter;
    import bank_cmd_arbiter_pkg::*;

    localparam int NB = 8;
    localparam int AW = 17;

    localparam logic [5:0] F_OTHER = 6'b101100;  // {ras,cas,we,is_cmd,is_read,is_write}: precharge
    localparam logic [5:0] F_ACT   = 6'b100100;
    localparam logic [5:0] F_RD    = 6'b010110;
    localparam logic [5:0] F_WR    = 6'b010101;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [7:0]    trrd = 8'd1;
    logic [7:0]    tfaw = 8'd1;
    logic [7:0]    tccd = 8'd1;
    logic [NB-1:0] v, ras, cas, we, isc, rd, wr;
    logic [AW-1:0] a_arr [NB];
    logic          ordy;

    int n_tests = 0;
    int n_fail  = 0;

    bank_cmd_arbiter_if #(.NBANKS(NB), .AW(AW)) bus ();

    bank_cmd_arbiter #(.NBANKS(NB), .AW(AW)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave),
        .tRRD_cfg(trrd),
        .tFAW_cfg(tfaw),
        .tCCD_cfg(tccd)
    );

    assign bus.bm_cmd_valid    = v;
    assign bus.bm_cmd_ras      = ras;
    assign bus.bm_cmd_cas      = cas;
    assign bus.bm_cmd_we       = we;
    assign bus.bm_cmd_is_cmd   = isc;
    assign bus.bm_cmd_is_read  = rd;
    assign bus.bm_cmd_is_write = wr;
    assign bus.out_ready       = ordy;
    for (genvar g = 0; g < NB; g++) begin : g_addr
        assign bus.bm_cmd_a[g*AW +: AW] = a_arr[g];
    end

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] valid;
        logic       ordy;
        logic [7:0] exp_rdy;
        logic       exp_ov;
        logic [2:0] exp_ba;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_bank(input int i, input logic [5:0] f, input logic [AW-1:0] addr);
        v[i] = 1'b1;
        a_arr[i] = addr;
        {ras[i], cas[i], we[i], isc[i], rd[i], wr[i]} = f;
    endtask

    function automatic logic [5:0] bank_flags(input int i);
        return {ras[i], cas[i], we[i], isc[i], rd[i], wr[i]};
    endfunction

    task automatic do_reset(input logic [7:0] r, input logic [7:0] f, input logic [7:0] c);
        trrd = r; tfaw = f; tccd = c;
        v = '0; ras = '0; cas = '0; we = '0; isc = '0; rd = '0; wr = '0;
        for (int i = 0; i < NB; i++) a_arr[i] = '0;
        ordy = 1'b1;
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    function automatic logic [25:0] out_payload();
        return {bus.out_a, bus.out_ba, bus.out_ras, bus.out_cas, bus.out_we,
                bus.out_is_cmd, bus.out_is_read, bus.out_is_write};
    endfunction

    // Reference model: timing rules expressed as elapsed-cycle distances from grant time stamps.
    task automatic run_random(input int ncyc);
        int         now, last_act, last_cas, ptr, w, faw_n, j;
        int         hist[$];
        logic       m_ov, sf;
        logic [25:0] m_pay;
        logic [5:0] f;
        logic       is_act, is_cas, ok;
        logic [NB-1:0] el, exp_rdy;
        now = 0; last_act = -100000; last_cas = -100000; ptr = NB - 1;
        m_ov = 1'b0; m_pay = '0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < NB; i++) begin
                case ($urandom_range(0, 4))
                    0: f = F_OTHER;
                    1: f = F_ACT;
                    2: f = F_RD;
                    3: f = F_WR;
                    default: f = 6'($urandom);
                endcase
                set_bank(i, f, AW'($urandom));
                v[i] = ($urandom_range(0, 2) != 0);
            end
            ordy = ($urandom_range(0, 3) != 0);
            #2;
            sf = !m_ov || ordy;
            faw_n = 0;
            foreach (hist[k]) if (now - hist[k] < int'(tfaw)) faw_n++;
            for (int i = 0; i < NB; i++) begin
                f = bank_flags(i);
                is_act = f[5] && !f[4] && !f[3] && f[2];
                is_cas = f[4] && (f[1] || f[0]);
                if (is_act)      ok = (now - last_act >= ((trrd == 8'd0) ? 1 : int'(trrd))) && (faw_n < 4);
                else if (is_cas) ok = (now - last_cas >= ((tccd == 8'd0) ? 1 : int'(tccd)));
                else             ok = 1'b1;
                el[i] = v[i] && ok;
            end
            w = -1;
            for (int k = 1; k <= NB; k++) begin
                j = (ptr + k) % NB;
                if (w < 0 && el[j]) w = j;
            end
            exp_rdy = (sf && w >= 0) ? (NB'(1) << w) : '0;
            chk("rand_ready", 32'(bus.bm_cmd_ready), 32'(exp_rdy));
            chk("rand_out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov) chk("rand_payload", 32'(out_payload()), 32'(m_pay));
            if (sf && w >= 0) begin
                f = bank_flags(w);
                m_ov = 1'b1;
                m_pay = {a_arr[w], 3'(w), f};
                ptr = w;
                if (f[5] && !f[4] && !f[3] && f[2]) begin
                    last_act = now;
                    hist.push_back(now);
                end
                if (f[4] && (f[1] || f[0])) last_cas = now;
            end else if (sf) begin
                m_ov = 1'b0;
            end
            while (hist.size() > 0 && now - hist[0] > 300) void'(hist.pop_front());
            now++;
            next();
        end
    endtask

    vec_t tbl [15];
    int   gi;
    logic [7:0] exp8;

    initial begin
        ordy = 1'b1;
        v = '0; ras = '0; cas = '0; we = '0; isc = '0; rd = '0; wr = '0;
        for (int i = 0; i < NB; i++) a_arr[i] = '0;

        // Round-robin vectors with OTHER commands only (no timing constraints).
        tbl[0]  = '{8'h21, 1'b1, 8'h01, 1'b0, 3'd0};
        tbl[1]  = '{8'h21, 1'b1, 8'h20, 1'b1, 3'd0};
        tbl[2]  = '{8'h21, 1'b1, 8'h01, 1'b1, 3'd5};
        tbl[3]  = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd0};
        tbl[4]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[5]  = '{8'h80, 1'b1, 8'h80, 1'b0, 3'd0};
        tbl[6]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd7};
        tbl[7]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd7};
        tbl[8]  = '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd7};
        tbl[9]  = '{8'h0C, 1'b1, 8'h04, 1'b1, 3'd0};
        tbl[10] = '{8'h0C, 1'b1, 8'h08, 1'b1, 3'd2};
        tbl[11] = '{8'h06, 1'b1, 8'h02, 1'b1, 3'd3};
        tbl[12] = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd1};
        tbl[13] = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd1};
        tbl[14] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};

        do_reset(8'd1, 8'd1, 8'd1);
        chk("reset_outputs", 32'(out_payload()), 32'd0);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < NB; i++) set_bank(i, F_OTHER, AW'(17'h100 + i));
        for (int r = 0; r < 15; r++) begin
            v = tbl[r].valid;
            ordy = tbl[r].ordy;
            #2;
            chk($sformatf("tbl%0d_ready", r), 32'(bus.bm_cmd_ready), 32'(tbl[r].exp_rdy));
            chk($sformatf("tbl%0d_valid", r), 32'(bus.out_valid), 32'(tbl[r].exp_ov));
            if (tbl[r].exp_ov) begin
                chk($sformatf("tbl%0d_ba", r), 32'(bus.out_ba), 32'(tbl[r].exp_ba));
                chk($sformatf("tbl%0d_a", r), 32'(bus.out_a), 32'h100 + 32'(tbl[r].exp_ba));
                chk($sformatf("tbl%0d_flags", r), 32'(out_payload() & 26'h3f), 32'(F_OTHER));
            end
            next();
        end

        // tRRD = 4: second ACT waits four cycles.
        do_reset(8'd4, 8'd1, 8'd1);
        set_bank(1, F_ACT, 17'h00111);
        set_bank(2, F_ACT, 17'h00222);
        #2;
        chk("trrd_first", 32'(bus.bm_cmd_ready), 32'h02);
        next();
        v[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #2;
            chk($sformatf("trrd_block_t%0d", k), 32'(bus.bm_cmd_ready), 32'h00);
            if (k == 1) chk("trrd_out_ba", 32'(bus.out_ba), 32'd1);
            next();
        end
        #2;
        chk("trrd_second", 32'(bus.bm_cmd_ready), 32'h04);
        next();

        // tFAW = 20: four back-to-back ACTs, then a gap until the window reopens.
        do_reset(8'd1, 8'd20, 8'd1);
        for (int i = 0; i < 5; i++) set_bank(i, F_ACT, AW'(i));
        gi = 0;
        for (int c = 0; c < 26; c++) begin
            #2;
            exp8 = 8'h00;
            if (c < 4 || (c >= 20 && c < 24)) begin
                exp8 = 8'(1 << (gi % 5));
                gi++;
            end
            chk($sformatf("tfaw_c%0d", c), 32'(bus.bm_cmd_ready), 32'(exp8));
            next();
        end

        // tCCD = 2: blocked CAS does not block an ACT from another bank.
        do_reset(8'd1, 8'd1, 8'd2);
        set_bank(3, F_RD, 17'h03333);
        set_bank(4, F_ACT, 17'h04444);
        #2;
        chk("tccd_cas_first", 32'(bus.bm_cmd_ready), 32'h08);
        next();
        #2;
        chk("tccd_act_passes", 32'(bus.bm_cmd_ready), 32'h10);
        next();
        v[4] = 1'b0;
        #2;
        chk("tccd_cas_again", 32'(bus.bm_cmd_ready), 32'h08);
        next();

        // Back-pressure: payload frozen, no accepts, regrant in the release cycle.
        do_reset(8'd1, 8'd1, 8'd1);
        set_bank(0, F_OTHER, 17'h00011);
        set_bank(1, F_OTHER, 17'h00022);
        set_bank(2, F_OTHER, 17'h00033);
        #2;
        chk("bp_first", 32'(bus.bm_cmd_ready), 32'h01);
        next();
        ordy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("bp_ready_%0d", k), 32'(bus.bm_cmd_ready), 32'h00);
            chk($sformatf("bp_valid_%0d", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_payload_%0d", k), 32'(out_payload()), 32'({17'h00011, 3'd0, F_OTHER}));
            next();
        end
        ordy = 1'b1;
        #2;
        chk("bp_release", 32'(bus.bm_cmd_ready), 32'h02);
        next();

        // Asynchronous reset with a held command, then bank 0 regains priority.
        do_reset(8'd1, 8'd1, 8'd1);
        for (int i = 0; i < NB; i++) set_bank(i, F_OTHER, AW'(i));
        next();
        next();
        #2;
        chk("arst_pre_valid", 32'(bus.out_valid), 32'd1);
        #1;
        sys_rst = 1'b1;
        #1;
        chk("arst_valid_low", 32'(bus.out_valid), 32'd0);
        chk("arst_no_ready", 32'(bus.bm_cmd_ready), 32'h00);
        next();
        chk("arst_hold_no_ready", 32'(bus.bm_cmd_ready), 32'h00);
        sys_rst = 1'b0;
        #2;
        chk("arst_bank0_first", 32'(bus.bm_cmd_ready), 32'h01);
        next();

        // Randomized traffic under several timing configurations.
        for (int p = 0; p < 4; p++) begin
            do_reset(8'($urandom_range(0, 5)), 8'($urandom_range(1, 24)), 8'($urandom_range(0, 4)));
            run_random(400);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
